fetch_opcode: RTL and testbench

Instruction-byte fetch stage sitting directly upstream of the opcode/register/ALU decoders. On request from the sequencer it reads from the byte bus, starting at the current PC:
- the opcode, with any page-2/page-3 prefix bytes;
- the opcode postbyte, where one is needed;
- the indexed-addressing postbyte.

It then presents `opcode`, `postbyte0`, `page2_valid`, `page3_valid` and `eapostbyte` as stable registered values, together with the next PC. Immediate, offset and extended operand bytes are not fetched here; the downstream sequencer fetches them starting at `pc_next_o`.

---
 rtl/fetch_opcode.sv | 163 ++++++++++++++++
 tb/tb_fetch_opcode.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_opcode.sv
// Instruction-byte fetch stage: reads prefix/opcode, register or page postbyte,
// and indexed postbyte from the byte bus, then presents them registered with the next PC.
module fetch_opcode #(
  parameter logic [7:0] RESET_OPCODE = 8'h12
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic        start_i,
  input  logic [15:0] pc_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ack_i,
  output logic [7:0]  opcode_o,
  output logic [7:0]  postbyte0_o,
  output logic        page2_valid_o,
  output logic        page3_valid_o,
  output logic [7:0]  eapostbyte_o,
  output logic [15:0] pc_next_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {IDLE, F_OP, F_PB, F_EA, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_d, pc_next_d;
  logic [DW-1:0]   opcode_d, pb0_d, ea_d;
  logic            p2_d, p3_d;
  logic            paged_q, paged_d;
  logic            page3_q, page3_d;
  logic            rd_d, busy_d, done_d;
  logic            op_is_prefix, op_is_regpb, op_is_ea, pb_is_ea;

  // Opcode classification of the byte currently on the bus
  always_comb begin
    op_is_prefix = (mem_data_i == 8'h10) || (mem_data_i == 8'h11);
    op_is_regpb  = (mem_data_i == 8'h1E) || (mem_data_i == 8'h1F) ||
                   (mem_data_i[7:2] == 6'b0011_01);
    op_is_ea     = (mem_data_i[7:2] == 6'b0011_00) || (mem_data_i[7:4] == 4'h6) ||
                   (mem_data_i[7:4] == 4'hA) || (mem_data_i[7:4] == 4'hE);
    pb_is_ea     = (mem_data_i[7:4] == 4'hA) || (mem_data_i[7:4] == 4'hE);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = mem_addr_o;
    opcode_d  = opcode_o;
    pb0_d     = postbyte0_o;
    ea_d      = eapostbyte_o;
    p2_d      = page2_valid_o;
    p3_d      = page3_valid_o;
    paged_d   = paged_q;
    page3_d   = page3_q;
    pc_next_d = pc_next_o;
    rd_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = pc_i;
          p2_d    = 1'b0;
          p3_d    = 1'b0;
          pb0_d   = '0;
          ea_d    = '0;
          paged_d = 1'b0;
          page3_d = 1'b0;
          state_d = F_OP;
        end
      end
      F_OP: begin
        if (mem_ack_i) begin
          opcode_d = mem_data_i;
          addr_d   = mem_addr_o + AW'(1);
          if (op_is_prefix) begin
            paged_d = 1'b1;
            page3_d = mem_data_i[0];
            state_d = F_PB;
          end else if (op_is_regpb) begin
            paged_d = 1'b0;
            state_d = F_PB;
          end else if (op_is_ea) begin
            state_d = F_EA;
          end else begin
            state_d = DONE;
          end
        end
      end
      F_PB: begin
        if (mem_ack_i) begin
          addr_d = mem_addr_o + AW'(1);
          if (paged_q && op_is_prefix) begin
            // Repeated prefix: the last one seen selects the page
            page3_d  = mem_data_i[0];
            opcode_d = mem_data_i;
          end else if (paged_q) begin
            pb0_d   = mem_data_i;
            p2_d    = ~page3_q;
            p3_d    = page3_q;
            state_d = pb_is_ea ? F_EA : DONE;
          end else begin
            pb0_d   = mem_data_i;
            state_d = DONE;
          end
        end
      end
      F_EA: begin
        if (mem_ack_i) begin
          ea_d    = mem_data_i;
          addr_d  = mem_addr_o + AW'(1);
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == F_OP) || (state_d == F_PB) || (state_d == F_EA);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == DONE) pc_next_d = addr_d;
  end

  // State and registered outputs
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q       <= IDLE;
      mem_addr_o    <= '0;
      mem_rd_o      <= 1'b0;
      opcode_o      <= RESET_OPCODE;
      postbyte0_o   <= '0;
      page2_valid_o <= 1'b0;
      page3_valid_o <= 1'b0;
      eapostbyte_o  <= '0;
      pc_next_o     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      paged_q       <= 1'b0;
      page3_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_o    <= addr_d;
      mem_rd_o      <= rd_d;
      opcode_o      <= opcode_d;
      postbyte0_o   <= pb0_d;
      page2_valid_o <= p2_d;
      page3_valid_o <= p3_d;
      eapostbyte_o  <= ea_d;
      pc_next_o     <= pc_next_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      paged_q       <= paged_d;
      page3_q       <= page3_d;
    end
  end

endmodule

// File: tb/tb_fetch_opcode.sv
// Scoreboard bench for fetch_opcode: byte-memory responder with wait states,
// expected fetch results queued at start and compared at done_o.
module tb_fetch_opcode;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  pb0;
    logic        p2;
    logic        p3;
    logic [7:0]  ea;
    logic [15:0] pcn;
    int          lat;
  } exp_t;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset;
  logic        start_i;
  logic [15:0] pc_i;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_data_i;
  logic        mem_ack_i;
  logic [7:0]  opcode_o, postbyte0_o, eapostbyte_o;
  logic        page2_valid_o, page3_valid_o;
  logic [15:0] pc_next_o;
  logic        busy_o, done_o;

  logic [7:0]  mem [0:65535];
  logic [16:0] rdq [$];
  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          read_idx, stall_cnt, wait_read, wait_n, watch_cnt;
  logic [15:0] watch_addr;

  fetch_opcode dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .start_i(start_i), .pc_i(pc_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .opcode_o(opcode_o), .postbyte0_o(postbyte0_o),
    .page2_valid_o(page2_valid_o), .page3_valid_o(page3_valid_o),
    .eapostbyte_o(eapostbyte_o), .pc_next_o(pc_next_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder, called once per falling edge
  task automatic bus_step();
    logic [16:0] ea;
    if (mem_rd_o) begin
      if (mem_addr_o == watch_addr) watch_cnt++;
      if (read_idx == wait_read && stall_cnt < wait_n) begin
        mem_ack_i  = 1'b0;
        mem_data_i = 8'($urandom);
        stall_cnt++;
      end else begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem[mem_addr_o];
        ea = (rdq.size() == 0) ? 17'h1_0000 : rdq.pop_front();
        check("rd_addr", 32'(mem_addr_o), 32'(ea));
        read_idx++;
        stall_cnt = 0;
      end
    end else begin
      mem_ack_i  = 1'b0;
      mem_data_i = 8'($urandom);
      read_idx   = 0;
      stall_cnt  = 0;
    end
  endtask

  task automatic fetch(input logic [15:0] pc, input exp_t e, input int nbytes, input bit poke);
    int cyc;
    bit got;
    exp_t x;
    for (int i = 0; i < nbytes; i++) rdq.push_back({1'b0, 16'(pc + 16'(i))});
    sb.push_back(e);
    pc_i    = pc;
    start_i = 1'b1;
    @(posedge cpu_clk);
    #1 start_i = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge cpu_clk);
      cyc++;
      bus_step();
      if (poke && cyc == 1) begin start_i = 1'b1; pc_i = pc ^ 16'h5A5A; end
      if (poke && cyc == 2) start_i = 1'b0;
      if (cyc == 1) check("pv_clear", 32'({page2_valid_o, page3_valid_o}), 32'(0));
      if ((page2_valid_o || page3_valid_o) && !done_o)
        check("pv_early", 32'(postbyte0_o), 32'(e.pb0));
      if (done_o) begin
        got = 1'b1;
        x = sb.pop_front();
        check("latency", 32'(cyc), 32'(x.lat));
        check("opcode", 32'(opcode_o), 32'(x.op));
        check("postbyte0", 32'(postbyte0_o), 32'(x.pb0));
        check("page2", 32'(page2_valid_o), 32'(x.p2));
        check("page3", 32'(page3_valid_o), 32'(x.p3));
        check("eapostbyte", 32'(eapostbyte_o), 32'(x.ea));
        check("pc_next", 32'(pc_next_o), 32'(x.pcn));
      end
    end
    start_i = 1'b0;
    if (!got) check("done_timeout", 32'(cyc), 32'(e.lat));
    check("reads_left", 32'(rdq.size()), 32'(0));
    rdq.delete();
    sb.delete();
    @(negedge cpu_clk);
    bus_step();
    check("done_pulse", 32'(done_o), 32'(0));
    check("hold_opcode", 32'(opcode_o), 32'(e.op));
    check("hold_pb0", 32'(postbyte0_o), 32'(e.pb0));
    check("hold_pc_next", 32'(pc_next_o), 32'(e.pcn));
  endtask

  function automatic exp_t mk(logic [7:0] op, logic [7:0] pb0, logic p2, logic p3,
                              logic [7:0] ea, logic [15:0] pcn, int lat);
    exp_t e;
    e.op = op; e.pb0 = pb0; e.p2 = p2; e.p3 = p3; e.ea = ea; e.pcn = pcn; e.lat = lat;
    return e;
  endfunction

  initial begin
    cpu_reset = 1'b1; start_i = 1'b0; pc_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    read_idx = 0; stall_cnt = 0; wait_read = -1; wait_n = 0;
    watch_addr = 16'h1234; watch_cnt = 0;
    mem[16'h0100] = 8'h86;
    mem[16'h2000] = 8'h10; mem[16'h2001] = 8'hAE; mem[16'h2002] = 8'h84;
    mem[16'h0300] = 8'h1F; mem[16'h0301] = 8'h89;
    mem[16'hFFFE] = 8'h10; mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h83;
    mem[16'h0500] = 8'h34; mem[16'h0501] = 8'h06;
    mem[16'h0600] = 8'hA6; mem[16'h0601] = 8'h84;
    mem[16'h0400] = 8'hA6; mem[16'h0401] = 8'h84;
    repeat (2) @(negedge cpu_clk);
    check("rst_rd", 32'(mem_rd_o), 32'(0));
    check("rst_addr", 32'(mem_addr_o), 32'(0));
    check("rst_opcode", 32'(opcode_o), 32'h12);
    check("rst_pb0", 32'(postbyte0_o), 32'(0));
    check("rst_ea", 32'(eapostbyte_o), 32'(0));
    check("rst_pv", 32'({page2_valid_o, page3_valid_o}), 32'(0));
    check("rst_pc_next", 32'(pc_next_o), 32'(0));
    check("rst_busy_done", 32'({busy_o, done_o}), 32'(0));
    cpu_reset = 1'b0;
    @(negedge cpu_clk);

    fetch(16'h0100, mk(8'h86, 8'h00, 0, 0, 8'h00, 16'h0101, 2), 1, 0);
    fetch(16'h2000, mk(8'h10, 8'hAE, 1, 0, 8'h84, 16'h2003, 4), 3, 0);

    wait_read = 1; wait_n = 2; watch_addr = 16'h0301; watch_cnt = 0;
    fetch(16'h0300, mk(8'h1F, 8'h89, 0, 0, 8'h00, 16'h0302, 5), 2, 0);
    check("wait_hold", 32'(watch_cnt), 32'(3));
    wait_read = -1; wait_n = 0; watch_addr = 16'h1234;

    fetch(16'hFFFE, mk(8'h11, 8'h83, 0, 1, 8'h00, 16'h0001, 4), 3, 0);
    fetch(16'h0500, mk(8'h34, 8'h06, 0, 0, 8'h00, 16'h0502, 3), 2, 1);
    fetch(16'h0600, mk(8'hA6, 8'h00, 0, 0, 8'h84, 16'h0602, 3), 2, 0);

    // Reset while the indexed postbyte read is stalled
    wait_read = 1; wait_n = 100;
    rdq.push_back({1'b0, 16'h0400});
    pc_i = 16'h0400; start_i = 1'b1;
    @(posedge cpu_clk);
    #1 start_i = 1'b0;
    repeat (3) begin @(negedge cpu_clk); bus_step(); end
    check("mid_rd", 32'({mem_rd_o, mem_addr_o}), 32'({1'b1, 16'h0401}));
    cpu_reset = 1'b1;
    @(negedge cpu_clk);
    check("mid_rst_rd", 32'(mem_rd_o), 32'(0));
    check("mid_rst_busy", 32'(busy_o), 32'(0));
    check("mid_rst_opcode", 32'(opcode_o), 32'h12);
    check("mid_rst_pv", 32'({page2_valid_o, page3_valid_o}), 32'(0));
    cpu_reset = 1'b0;
    mem_ack_i = 1'b1; mem_data_i = 8'h84;
    @(negedge cpu_clk);
    check("late_ack_rd", 32'(mem_rd_o), 32'(0));
    check("late_ack_busy", 32'(busy_o), 32'(0));
    check("late_ack_ea", 32'(eapostbyte_o), 32'(0));
    mem_ack_i = 1'b0;
    wait_read = -1; wait_n = 0;
    rdq.delete();
    @(negedge cpu_clk);
    bus_step();
    fetch(16'h0100, mk(8'h86, 8'h00, 0, 0, 8'h00, 16'h0101, 2), 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
